// File: rtl/vga_text_pkg.sv
// vga_text_pkg: character codes, fetch FSM states and nibble-to-glyph mapping
// shared by the register text fetcher and the on-screen renderer.
package vga_text_pkg;
    localparam logic [5:0] CH_R      = 6'd52;
    localparam logic [5:0] CH_COLON  = 6'd17;
    localparam logic [5:0] CH_SPACE  = 6'd18;
    localparam int         TEXT_COLS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } fetch_state_e;

    // glyph table stores hex digits 0..F at codes 0..15
    function automatic logic [5:0] hex_nibble(input logic [3:0] n);
        return {2'b00, n};
    endfunction
endpackage

// File: rtl/text_buffer_ram.sv
// text_buffer_ram: character store with one write port and a registered
// read-before-write read port; out-of-range reads return a space.
module text_buffer_ram
    import vga_text_pkg::*;
#(
    parameter int DEPTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [5:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [5:0]    o_rdata
);
    logic [5:0] r_mem [DEPTH];
    logic [5:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= CH_SPACE;
        else          r_rdata <= i_re ? r_mem[i_raddr] : CH_SPACE;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/reg_text_fetcher.sv
// reg_text_fetcher: scans the CPU register file and renders each 32-bit value
// as a 12-character text row (R, index, colon, 8 hex digits) for the renderer.
module reg_text_fetcher
    import vga_text_pkg::*;
#(
    parameter int         NUM_REGS   = 8,
    parameter logic [8:0] BASE_ADDR  = 9'd0,
    parameter int         RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        continuous,
    output logic [8:0]  addr,
    input  logic [31:0] register_value,
    output logic        finished_register,
    output logic        frame_done,
    output logic        busy,
    input  logic [3:0]  rd_row,
    input  logic [3:0]  rd_col,
    output logic [5:0]  rd_char
);
    localparam int         DEPTH    = NUM_REGS * TEXT_COLS;
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAST_ROW = 4'(NUM_REGS - 1);
    localparam logic [3:0] LAST_COL = 4'(TEXT_COLS - 1);
    localparam logic [1:0] LAST_LAT = 2'(RD_LATENCY - 1);

    fetch_state_e  r_state;
    logic [3:0]    r_idx;
    logic [3:0]    r_col;
    logic [1:0]    r_lat;
    logic [31:0]   r_shadow;
    logic [8:0]    r_addr;
    logic          r_fin;
    logic          r_frame;
    logic          r_busy;
    logic [7:0]    w_idx8;
    logic [5:0]    w_sh;
    logic [3:0]    w_nib;
    logic [5:0]    w_wchar;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic          w_rd_ok;

    assign w_idx8  = 8'(r_idx);
    // value digits start at col 4 with the most significant nibble
    assign w_sh    = 6'd28 - {r_col - 4'd4, 2'b00};
    assign w_nib   = 4'(r_shadow >> w_sh);
    assign w_wchar = r_col == 4'd0 ? CH_R :
                     r_col == 4'd1 ? hex_nibble(w_idx8[7:4]) :
                     r_col == 4'd2 ? hex_nibble(w_idx8[3:0]) :
                     r_col == 4'd3 ? CH_COLON : hex_nibble(w_nib);
    assign w_waddr = AW'(8'(r_idx) * 8'd12 + 8'(r_col));
    assign w_raddr = AW'(8'(rd_row) * 8'd12 + 8'(rd_col));
    assign w_rd_ok = (5'(rd_row) < 5'(NUM_REGS)) && (rd_col <= LAST_COL);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_col    <= '0;
            r_lat    <= '0;
            r_shadow <= '0;
            r_addr   <= BASE_ADDR;
            r_fin    <= 1'b0;
            r_frame  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_fin   <= 1'b0;
            r_frame <= 1'b0;
            case (r_state)
                ST_IDLE: if (start | continuous) begin
                    r_state <= ST_ADDR;
                    r_busy  <= 1'b1;
                    r_addr  <= BASE_ADDR;
                    r_lat   <= '0;
                end
                ST_ADDR: if (r_lat == LAST_LAT) r_state <= ST_CAPTURE;
                         else r_lat <= r_lat + 2'd1;
                ST_CAPTURE: begin
                    r_shadow <= register_value;
                    r_col    <= '0;
                    r_state  <= ST_EMIT;
                end
                ST_EMIT: if (r_col == LAST_COL) begin
                    r_fin <= 1'b1;
                    if (r_idx == LAST_ROW) r_state <= ST_DONE;
                    else begin
                        r_idx   <= r_idx + 4'd1;
                        r_addr  <= BASE_ADDR + 9'(r_idx) + 9'd1;
                        r_lat   <= '0;
                        r_state <= ST_ADDR;
                    end
                end else r_col <= r_col + 4'd1;
                ST_DONE: begin
                    r_frame <= 1'b1;
                    r_idx   <= '0;
                    r_lat   <= '0;
                    if (continuous) begin
                        r_state <= ST_ADDR;
                        r_addr  <= BASE_ADDR;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    text_buffer_ram #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_we    (r_state == ST_EMIT),
        .i_waddr (w_waddr),
        .i_wdata (w_wchar),
        .i_re    (w_rd_ok),
        .i_raddr (w_raddr),
        .o_rdata (rd_char)
    );

    assign addr              = r_addr;
    assign finished_register = r_fin;
    assign frame_done        = r_frame;
    assign busy              = r_busy;
endmodule

// File: tb/tb_reg_text_fetcher.sv
// tb_reg_text_fetcher: scoreboard bench; stimulus pushes expected pulse cycles
// and read data into queues, a negedge monitor pops and compares.
module tb_reg_text_fetcher;
    import vga_text_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [8:0]  addr;
    logic [31:0] register_value = '0;
    logic        finished_register;
    logic        frame_done;
    logic        busy;
    logic [3:0]  rd_row = '0;
    logic [3:0]  rd_col = '0;
    logic [5:0]  rd_char;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        use_addr = 1'b0;
    logic [31:0] model_val = '0;
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    int          fr_q[$];
    int          fd_q[$];
    logic [5:0]  rd_q[$];
    string       rd_name_q[$];

    reg_text_fetcher #(.NUM_REGS(8), .BASE_ADDR(9'd0), .RD_LATENCY(1)) dut (
        .clock             (clock),
        .resetn            (resetn),
        .start             (start),
        .continuous        (continuous),
        .addr              (addr),
        .register_value    (register_value),
        .finished_register (finished_register),
        .frame_done        (frame_done),
        .busy              (busy),
        .rd_row            (rd_row),
        .rd_col            (rd_col),
        .rd_char           (rd_char)
    );

    always #5 clock = ~clock;

    // register file model with one cycle read latency
    always @(posedge clock) begin
        cyc            <= cyc + 1;
        rd_pend        <= rd_req;
        register_value <= use_addr ? 32'(addr) : model_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && finished_register) begin
            if (fr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL finished_register: unexpected pulse at cycle %0d, expected none", cyc);
            end else check("finished_register cycle", cyc, fr_q.pop_front());
        end
        if (resetn && frame_done) begin
            if (fd_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL frame_done: unexpected pulse at cycle %0d, expected none", cyc);
            end else check("frame_done cycle", cyc, fd_q.pop_front());
        end
        if (rd_pend && rd_q.size() != 0) check(rd_name_q.pop_front(), rd_char, rd_q.pop_front());
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_frame(input int s, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int k = 1; k <= 8; k++) fr_q.push_back(s + 1 + 113 * f + 14 * k);
            fd_q.push_back(s + 1 + 113 * (f + 1));
        end
    endtask

    task automatic rd(input logic [3:0] r, input logic [3:0] c, input logic [5:0] e, input string n);
        rd_row = r;
        rd_col = c;
        rd_q.push_back(e);
        rd_name_q.push_back(n);
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((fr_q.size() != 0 || fd_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (fr_q.size() != 0 || fd_q.size() != 0) begin
            fails++;
            $display("FAIL frame timeout: %0d pulses still pending, expected 0", fr_q.size() + fd_q.size());
            fr_q.delete();
            fd_q.delete();
        end
    endtask

    initial begin
        int s;
        logic [5:0] row3 [12] = '{6'd52, 6'd0, 6'd3, 6'd17, 6'd13, 6'd14,
                                  6'd10, 6'd13, 6'd11, 6'd14, 6'd14, 6'd15};
        tick(3);
        check("reset busy", busy, 0);
        check("reset addr", addr, 0);
        check("reset finished_register", finished_register, 0);
        check("reset frame_done", frame_done, 0);
        check("reset rd_char", rd_char, 18);
        resetn = 1'b1;
        tick(2);

        // single frame of DEADBEEF
        model_val = 32'hDEADBEEF;
        s = cyc;
        start = 1'b1;
        push_frame(s, 1);
        tick();
        start = 1'b0;
        check("busy after start", busy, 1);
        while (cyc < s + 113) tick();
        check("busy before frame_done", busy, 1);
        tick();
        check("busy after frame_done", busy, 0);
        wait_done(50);
        for (int c = 0; c < 12; c++) rd(4'd3, 4'(c), row3[c], $sformatf("row3 col%0d", c));

        // start while busy is ignored
        s = cyc;
        start = 1'b1;
        push_frame(s, 1);
        tick();
        start = 1'b0;
        tick(19);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300);
        tick(130);
        check("busy idle after ignored start", busy, 0);

        // continuous back-to-back frames, value changes for the second
        s = cyc;
        continuous = 1'b1;
        push_frame(s, 2);
        while (cyc < s + 114) tick();
        model_val = 32'h00000001;
        continuous = 1'b0;
        check("no idle gap busy", busy, 1);
        wait_done(300);
        tick(2);
        check("busy after continuous drop", busy, 0);
        rd(4'd0, 4'd11, 6'd1, "frame2 row0 col11");
        rd(4'd0, 4'd4, 6'd0, "frame2 row0 col4");
        rd(4'd7, 4'd11, 6'd1, "frame2 row7 col11");
        rd(4'd7, 4'd2, 6'd7, "frame2 row7 col2");

        // reset during EMIT of row 5 after its col 4 was written
        model_val = 32'h12345678;
        s = cyc;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) fr_q.push_back(s + 1 + 14 * k);
        tick();
        start = 1'b0;
        while (cyc < s + 78) tick();
        check("pulses before reset", fr_q.size(), 0);
        fr_q.delete();
        resetn = 1'b0;
        #1;
        check("busy on reset", busy, 0);
        check("addr on reset", addr, 0);
        tick(2);
        resetn = 1'b1;
        tick();
        rd(4'd4, 4'd11, 6'd8, "partial row4 col11");
        rd(4'd5, 4'd4, 6'd1, "partial row5 col4");
        rd(4'd5, 4'd5, 6'd0, "partial row5 col5 old");
        rd(4'd6, 4'd11, 6'd1, "partial row6 col11 old");

        // rescan from row 0 with register value = address
        use_addr = 1'b1;
        s = cyc;
        start = 1'b1;
        push_frame(s, 1);
        tick();
        start = 1'b0;
        while (cyc < s + 50) tick();
        check("addr row3 held in emit", addr, 3);
        wait_done(200);
        rd(4'd0, 4'd11, 6'd0, "rescan row0 col11");
        rd(4'd2, 4'd11, 6'd2, "rescan row2 col11");
        rd(4'd7, 4'd11, 6'd7, "rescan row7 col11");
        rd(4'd7, 4'd2, 6'd7, "rescan row7 col2");
        rd(4'd3, 4'd10, 6'd0, "rescan row3 col10");

        // read/write collision on (2,7), then out-of-range reads
        use_addr = 1'b0;
        model_val = 32'hCAFEF00D;
        s = cyc;
        start = 1'b1;
        push_frame(s, 1);
        tick();
        start = 1'b0;
        while (cyc < s + 38) tick();
        rd(4'd2, 4'd7, 6'd0, "collision old");
        rd(4'd2, 4'd7, 6'd14, "collision new");
        rd(4'd9, 4'd0, 6'd18, "out of range row");
        rd(4'd0, 4'd12, 6'd18, "out of range col");
        wait_done(200);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
